// File: rtl/scan_decoder_low.sv
// One-cold, active-low N-to-2^N decoder with break-before-make blanking and autonomous scan.
// Optional macro SCAN_REVERSE_EN adds a dir input for descending scan order.
module scan_decoder_low #(
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned DWELL_W   = 8,
  parameter int unsigned BLANK_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [DWELL_W-1:0]     dwell,
`ifdef SCAN_REVERSE_EN
  input  logic                   dir,
`endif
  output logic [(2**SEL_W)-1:0]  d_n,
  output logic [SEL_W-1:0]       idx,
  output logic                   wrap
);

  localparam int unsigned N          = 2 ** SEL_W;
  localparam int unsigned BLANK_W    = (BLANK_CYC > 2) ? $clog2(BLANK_CYC) : 1;
  localparam int unsigned BLANK_LOAD = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;
  localparam logic [SEL_W-1:0] FIRST = SEL_W'(0);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(N - 1);

  typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     idx_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [BLANK_W-1:0]   blank_q, blank_d;
  logic                 pend_q, pend_d;
  logic                 wrap_d;
  logic [N-1:0]         d_n_d;
  logic                 rev;
  logic                 change;
  logic                 wrap_evt;
  logic [SEL_W-1:0]     step_idx;
  logic [SEL_W-1:0]     start_idx;
  logic [SEL_W-1:0]     wrap_from;

`ifdef SCAN_REVERSE_EN
  assign rev = dir;
`else
  assign rev = 1'b0;
`endif

  // Scan direction dependent constants and successor index
  always_comb begin
    step_idx  = rev ? (idx - SEL_W'(1)) : (idx + SEL_W'(1));
    start_idx = rev ? LAST : FIRST;
    wrap_from = rev ? FIRST : LAST;
  end

  // Next-state, next-index and registered-output decode
  always_comb begin
    state_d  = state_q;
    idx_d    = idx;
    dwell_d  = dwell_q;
    blank_d  = blank_q;
    pend_d   = pend_q;
    wrap_d   = 1'b0;
    change   = 1'b0;
    wrap_evt = 1'b0;
    d_n_d    = '1;

    if (!en) begin
      state_d = IDLE;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          idx_d  = mode ? start_idx : sel;
          pend_d = 1'b0;
          change = 1'b1;
        end
        BLANK: begin
          if (blank_q == '0) begin
            state_d = ACTIVE;
            dwell_d = dwell;
            wrap_d  = pend_q;
            pend_d  = 1'b0;
          end else begin
            blank_d = blank_q - BLANK_W'(1);
          end
        end
        ACTIVE: begin
          if (!mode) begin
            // Keep the dwell counter primed so a switch to scan starts a fresh dwell
            dwell_d = dwell;
            if (sel != idx) begin
              idx_d  = sel;
              change = 1'b1;
            end
          end else if (dwell_q == '0) begin
            idx_d    = step_idx;
            change   = 1'b1;
            wrap_evt = (idx == wrap_from);
          end else begin
            dwell_d = dwell_q - DWELL_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase

      // Every line change passes through BLANK unless blanking is disabled
      if (change) begin
        if (BLANK_CYC == 0) begin
          state_d = ACTIVE;
          dwell_d = dwell;
          wrap_d  = wrap_evt;
        end else begin
          state_d = BLANK;
          blank_d = BLANK_W'(BLANK_LOAD);
          pend_d  = wrap_evt;
        end
      end
    end

    if (state_d == ACTIVE) begin
      d_n_d[idx_d] = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx     <= '0;
      dwell_q <= '0;
      blank_q <= '0;
      pend_q  <= 1'b0;
      wrap    <= 1'b0;
      d_n     <= '1;
    end else begin
      state_q <= state_d;
      idx     <= idx_d;
      dwell_q <= dwell_d;
      blank_q <= blank_d;
      pend_q  <= pend_d;
      wrap    <= wrap_d;
      d_n     <= d_n_d;
    end
  end

endmodule
